lego_hdr_codec: RTL

//  Generalised Lego header codec between the network stream and an application. Net->App: strips a
//  HDR_BEATS-beat (ETH+Lego+pad) header from EVERY frame and stores it per channel. App->Net: buffers

---
 rtl/lego_hdr_codec.sv | 316 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lego_hdr_codec.sv
// Lego header codec: strips a per-channel header from every net frame and
// prepends the stored header of the matching channel to buffered app frames.
//
// state   | meaning
// RX_HDR  | collecting header beats into the shadow buffer
// RX_PAY  | passing payload straight through to toApp
// TX_IDLE | waiting for a buffered app frame
// TX_HDR  | emitting the snapshot header
// TX_PAY  | forwarding buffered payload beats
// TX_DROP | discarding a frame whose channel has no header
module lego_hdr_codec #(
  parameter int DW         = 64,
  parameter int UW         = 64,
  parameter int HDR_BEATS  = 3,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic              apclk,
  input  logic              apresetn,
  input  logic [DW-1:0]     fromNet_axis_tdata,
  input  logic [DW/8-1:0]   fromNet_axis_tkeep,
  input  logic [UW-1:0]     fromNet_axis_tuser,
  input  logic              fromNet_axis_tlast,
  input  logic              fromNet_axis_tvalid,
  output logic              fromNet_axis_tready,
  output logic [DW-1:0]     toApp_axis_tdata,
  output logic [DW/8-1:0]   toApp_axis_tkeep,
  output logic [UW-1:0]     toApp_axis_tuser,
  output logic              toApp_axis_tlast,
  output logic              toApp_axis_tvalid,
  input  logic              toApp_axis_tready,
  input  logic [DW-1:0]     fromApp_axis_tdata,
  input  logic [DW/8-1:0]   fromApp_axis_tkeep,
  input  logic [UW-1:0]     fromApp_axis_tuser,
  input  logic              fromApp_axis_tlast,
  input  logic              fromApp_axis_tvalid,
  output logic              fromApp_axis_tready,
  output logic [DW-1:0]     toNet_axis_tdata,
  output logic [DW/8-1:0]   toNet_axis_tkeep,
  output logic [UW-1:0]     toNet_axis_tuser,
  output logic              toNet_axis_tlast,
  output logic              toNet_axis_tvalid,
  input  logic              toNet_axis_tready,
  output logic [NUM_CH-1:0] hdr_valid,
  output logic [CNT_W-1:0]  rx_frames,
  output logic [CNT_W-1:0]  rx_runts,
  output logic [CNT_W-1:0]  tx_frames,
  output logic [CNT_W-1:0]  tx_drops
);

  localparam int KW  = DW / 8;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HCW = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int FW  = DW + KW + UW + 1;
  localparam logic [HCW-1:0] HDR_LAST = HCW'(HDR_BEATS - 1);

  typedef enum logic {RX_HDR, RX_PAY} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_PAY, TX_DROP} tx_state_e;

  function automatic logic ch_in_range(input logic [CHW-1:0] ch);
    return ({{(32-CHW){1'b0}}, ch} < 32'(NUM_CH));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---------------- RX path ----------------
  rx_state_e         rx_q, rx_d;
  logic [HCW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [CHW-1:0]    rx_ch_q, rx_ch_d;
  logic [NUM_CH-1:0] hdr_valid_q, hdr_valid_d;
  logic [CNT_W-1:0]  rx_frames_q, rx_frames_d, rx_runts_q, rx_runts_d;
  logic [DW-1:0]     shadow_q [HDR_BEATS];
  logic [DW-1:0]     hdr_tbl_q [NUM_CH][HDR_BEATS];
  logic              rx_beat, rx_hdr_beat, rx_commit;
  logic [CHW-1:0]    rx_ch_cur;

  assign fromNet_axis_tready = (rx_q == RX_PAY) ? toApp_axis_tready : 1'b1;
  assign toApp_axis_tvalid   = (rx_q == RX_PAY) & fromNet_axis_tvalid;
  assign toApp_axis_tdata    = fromNet_axis_tdata;
  assign toApp_axis_tkeep    = fromNet_axis_tkeep;
  assign toApp_axis_tuser    = fromNet_axis_tuser;
  assign toApp_axis_tlast    = fromNet_axis_tlast;

  assign rx_beat     = fromNet_axis_tvalid & fromNet_axis_tready;
  assign rx_hdr_beat = (rx_q == RX_HDR) & rx_beat;
  // The channel comes from beat 0, which may also be the final header beat.
  assign rx_ch_cur   = (rx_cnt_q == '0) ? fromNet_axis_tuser[CHW-1:0] : rx_ch_q;
  assign rx_commit   = rx_hdr_beat & (rx_cnt_q == HDR_LAST) & ~fromNet_axis_tlast
                       & ch_in_range(rx_ch_cur);

  always_comb begin
    rx_d        = rx_q;
    rx_cnt_d    = rx_cnt_q;
    rx_ch_d     = rx_ch_q;
    hdr_valid_d = hdr_valid_q;
    rx_frames_d = rx_frames_q;
    rx_runts_d  = rx_runts_q;
    case (rx_q)
      RX_HDR: begin
        if (rx_beat) begin
          if (rx_cnt_q == '0) rx_ch_d = fromNet_axis_tuser[CHW-1:0];
          if (fromNet_axis_tlast) begin
            rx_cnt_d   = '0;
            rx_runts_d = sat_inc(rx_runts_q);
          end else if (rx_cnt_q == HDR_LAST) begin
            rx_cnt_d = '0;
            rx_d     = RX_PAY;
            if (rx_commit) hdr_valid_d[rx_ch_cur] = 1'b1;
            else           rx_runts_d = sat_inc(rx_runts_q);
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      RX_PAY: begin
        if (rx_beat && fromNet_axis_tlast) begin
          rx_d        = RX_HDR;
          rx_frames_d = sat_inc(rx_frames_q);
        end
      end
      default: rx_d = RX_HDR;
    endcase
  end

  always_ff @(posedge apclk or negedge apresetn) begin
    if (!apresetn) begin
      rx_q        <= RX_HDR;
      rx_cnt_q    <= '0;
      rx_ch_q     <= '0;
      hdr_valid_q <= '0;
      rx_frames_q <= '0;
      rx_runts_q  <= '0;
    end else begin
      rx_q        <= rx_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_ch_q     <= rx_ch_d;
      hdr_valid_q <= hdr_valid_d;
      rx_frames_q <= rx_frames_d;
      rx_runts_q  <= rx_runts_d;
    end
  end

  // Final header beat goes straight into the table so the commit takes one cycle.
  always_ff @(posedge apclk) begin
    if (rx_hdr_beat) shadow_q[rx_cnt_q] <= fromNet_axis_tdata;
    if (rx_commit) begin
      for (int b = 0; b < HDR_BEATS - 1; b++) hdr_tbl_q[rx_ch_cur][b] <= shadow_q[b];
      hdr_tbl_q[rx_ch_cur][HDR_BEATS-1] <= fromNet_axis_tdata;
    end
  end

  // ---------------- App buffer ----------------
  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic           fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [DW-1:0]  head_data;
  logic [KW-1:0]  head_keep;
  logic [UW-1:0]  head_user;
  logic           head_last;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fromApp_axis_tready = ~fifo_full;
  assign fifo_wr = fromApp_axis_tvalid & ~fifo_full;
  assign {head_data, head_keep, head_user, head_last} = fifo_mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge apclk) begin
    if (fifo_wr)
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= {fromApp_axis_tdata, fromApp_axis_tkeep,
                                       fromApp_axis_tuser, fromApp_axis_tlast};
  end

  always_ff @(posedge apclk or negedge apresetn) begin
    if (!apresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ---------------- TX path ----------------
  tx_state_e        tx_q, tx_d;
  logic [HCW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [UW-1:0]    tx_user_q, tx_user_d;
  logic [DW-1:0]    snap_q [HDR_BEATS];
  logic             snap_load;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [KW-1:0]    out_keep_q, out_keep_d;
  logic [UW-1:0]    out_user_q, out_user_d;
  logic [CNT_W-1:0] tx_frames_q, tx_frames_d, tx_drops_q, tx_drops_d;
  logic             can_load, head_ok;
  logic [CHW-1:0]   head_ch;

  assign can_load = ~out_valid_q | toNet_axis_tready;
  assign head_ch  = head_user[CHW-1:0];
  assign head_ok  = ch_in_range(head_ch) && hdr_valid_q[head_ch];

  always_comb begin
    tx_d        = tx_q;
    tx_cnt_d    = tx_cnt_q;
    tx_user_d   = tx_user_q;
    snap_load   = 1'b0;
    fifo_rd     = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_user_d  = out_user_q;
    out_last_d  = out_last_q;
    tx_frames_d = (out_valid_q && toNet_axis_tready && out_last_q) ? sat_inc(tx_frames_q)
                                                                   : tx_frames_q;
    tx_drops_d  = tx_drops_q;
    if (can_load) out_valid_d = 1'b0;
    case (tx_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          tx_user_d = head_user;
          tx_cnt_d  = '0;
          if (head_ok) begin
            snap_load = 1'b1;
            tx_d      = TX_HDR;
          end else begin
            tx_d = TX_DROP;
          end
        end
      end
      TX_HDR: begin
        if (can_load) begin
          out_valid_d = 1'b1;
          out_data_d  = snap_q[tx_cnt_q];
          out_keep_d  = '1;
          out_user_d  = tx_user_q;
          out_last_d  = 1'b0;
          if (tx_cnt_q == HDR_LAST) begin
            tx_cnt_d = '0;
            tx_d     = TX_PAY;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
      TX_PAY: begin
        if (can_load && !fifo_empty) begin
          fifo_rd     = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = head_data;
          out_keep_d  = head_keep;
          out_user_d  = head_user;
          out_last_d  = head_last;
          if (head_last) tx_d = TX_IDLE;
        end
      end
      TX_DROP: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          if (head_last) begin
            tx_drops_d = sat_inc(tx_drops_q);
            tx_d       = TX_IDLE;
          end
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge apclk or negedge apresetn) begin
    if (!apresetn) begin
      tx_q        <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_user_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
      tx_frames_q <= '0;
      tx_drops_q  <= '0;
    end else begin
      tx_q        <= tx_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_user_q   <= tx_user_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
      tx_frames_q <= tx_frames_d;
      tx_drops_q  <= tx_drops_d;
    end
  end

  // Snapshot reads the pre-edge table, so a same-cycle RX commit is not seen.
  always_ff @(posedge apclk) begin
    if (snap_load)
      for (int b = 0; b < HDR_BEATS; b++) snap_q[b] <= hdr_tbl_q[head_ch][b];
  end

  assign toNet_axis_tvalid = out_valid_q;
  assign toNet_axis_tdata  = out_data_q;
  assign toNet_axis_tkeep  = out_keep_q;
  assign toNet_axis_tuser  = out_user_q;
  assign toNet_axis_tlast  = out_last_q;

  assign hdr_valid = hdr_valid_q;
  assign rx_frames = rx_frames_q;
  assign rx_runts  = rx_runts_q;
  assign tx_frames = tx_frames_q;
  assign tx_drops  = tx_drops_q;

endmodule
